// File: rtl/cic_pkg.sv
// Shared sizing and configuration-legality helpers for the programmable CIC decimator.
package cic_pkg;

    function automatic int clog2_l(input longint value);
        int     r;
        longint p;
        r = 0;
        p = 1;
        while (p < value) begin
            p = p << 1;
            r++;
        end
        return r;
    endfunction

    // Register growth of an unpruned chain: INP_DW + log2 of the DC gain (R*M)**N.
    function automatic int b_max_f(input int inp_dw, input int r_max, input int n, input int m);
        longint gain;
        gain = 1;
        for (int i = 0; i < n; i++)
            gain = gain * longint'(r_max * m);
        return inp_dw + clog2_l(gain);
    endfunction

    function automatic int shw_f(input int b_max);
        return clog2_l(longint'(b_max) + 1);
    endfunction

    function automatic int rw_f(input int r_max);
        return clog2_l(longint'(r_max) + 1);
    endfunction

    function automatic logic cfg_legal(input int ratio, input int shift, input int r_max,
                                       input int inp_dw, input int out_dw, input int b_max);
        return (ratio >= 2) && (ratio <= r_max) &&
               (shift >= out_dw - inp_dw) && (shift <= b_max - out_dw);
    endfunction

endpackage

// File: rtl/cic_comb_stage.sv
// One CIC comb section y = x - x[n-M], registered, advancing only on valid input.
module cic_comb_stage #(
    parameter int W = 48,
    parameter int M = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                flush,
    input  logic                in_valid,
    input  logic signed [W-1:0] in_data,
    output logic                out_valid,
    output logic signed [W-1:0] out_data
);

    logic signed [W-1:0] dly [M];

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            // NOTE: the delay line is cleared because the chain must restart from a zero
            // history; a plain data memory would normally be left without reset.
            for (int i = 0; i < M; i++)
                dly[i] <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                out_data <= in_data - dly[M-1];
                dly[0]   <= in_data;
                for (int i = 1; i < M; i++)
                    dly[i] <= dly[i-1];
            end
        end
    end

endmodule

// File: rtl/cic_d_prog.sv
// Programmable-ratio CIC decimator: integrators at the input rate, combs at the decimated
// rate, then a programmable arithmetic shift with saturation to the output width.
module cic_d_prog
    import cic_pkg::*;
#(
    parameter int INP_DW    = 18,
    parameter int OUT_DW    = 18,
    parameter int CIC_R_MAX = 64,
    parameter int CIC_N     = 5,
    parameter int CIC_M     = 1,
    parameter int SHIFT_RST = 30
) (
    input  logic                                                        clk,
    input  logic                                                        reset,
    input  logic signed [INP_DW-1:0]                                    inp_samp_data,
    input  logic                                                        inp_samp_str,
    input  logic [rw_f(CIC_R_MAX)-1:0]                                  cfg_ratio,
    input  logic [shw_f(b_max_f(INP_DW, CIC_R_MAX, CIC_N, CIC_M))-1:0] cfg_shift,
    input  logic                                                        cfg_str,
    output logic                                                        cfg_err,
    output logic signed [OUT_DW-1:0]                                    out_samp_data,
    output logic                                                        out_samp_str,
    output logic                                                        out_sat
);

    localparam int B_MAX = b_max_f(INP_DW, CIC_R_MAX, CIC_N, CIC_M);
    localparam int SHW   = shw_f(B_MAX);
    localparam int RW    = rw_f(CIC_R_MAX);
    localparam int WW    = clog2_l(longint'(CIC_N) + 1);

    localparam logic signed [B_MAX-1:0] WMAX = {{(B_MAX-OUT_DW+1){1'b0}}, {(OUT_DW-1){1'b1}}};
    localparam logic signed [B_MAX-1:0] WMIN = {{(B_MAX-OUT_DW+1){1'b1}}, {(OUT_DW-1){1'b0}}};

    logic [RW-1:0]            ratio_q;
    logic [SHW-1:0]           shift_q;
    logic [RW-1:0]            phase_q;
    logic [WW-1:0]            warm_q;
    logic signed [B_MAX-1:0]  integ_q [CIC_N];
    logic signed [B_MAX-1:0]  integ_d [CIC_N];
    logic signed [B_MAX-1:0]  ds_q;
    logic                     ds_valid_q;
    logic signed [B_MAX-1:0]  inp_ext;
    logic signed [B_MAX-1:0]  comb_data [CIC_N+1];
    logic [CIC_N:0]           comb_valid;
    logic                     cfg_acc;
    logic                     cfg_rej;
    logic                     samp_en;
    logic                     dec;
    logic [SHW:0]             sh_tot;
    logic signed [B_MAX-1:0]  scaled;
    logic signed [OUT_DW-1:0] sat_data;
    logic                     clip;

    assign cfg_acc = cfg_str && cfg_legal(int'(cfg_ratio), int'(cfg_shift), CIC_R_MAX,
                                          INP_DW, OUT_DW, B_MAX);
    assign cfg_rej = cfg_str && !cfg_acc;
    // An accepted configuration flushes the chain, so a coincident sample is discarded.
    assign samp_en = inp_samp_str && !cfg_acc;
    assign dec     = samp_en && (phase_q == ratio_q - RW'(1));
    assign inp_ext = {{(B_MAX-INP_DW){inp_samp_data[INP_DW-1]}}, inp_samp_data};

    // Integrators cascade combinationally so the decimated value includes the current strobe.
    always_comb begin
        logic signed [B_MAX-1:0] acc;
        // NOTE: blocking assignments here build the adder cascade within one cycle;
        // registered state elsewhere uses non-blocking assignments only.
        acc = inp_ext;
        for (int k = 0; k < CIC_N; k++) begin
            acc        = integ_q[k] + acc;
            integ_d[k] = acc;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ratio_q    <= RW'(CIC_R_MAX);
            shift_q    <= SHW'(SHIFT_RST);
            phase_q    <= '0;
            warm_q     <= WW'(CIC_N);
            ds_q       <= '0;
            ds_valid_q <= 1'b0;
            cfg_err    <= 1'b0;
            for (int k = 0; k < CIC_N; k++)
                integ_q[k] <= '0;
        end else begin
            cfg_err <= cfg_rej;
            if (cfg_acc) begin
                ratio_q    <= cfg_ratio;
                shift_q    <= cfg_shift;
                phase_q    <= '0;
                warm_q     <= WW'(CIC_N);
                ds_q       <= '0;
                ds_valid_q <= 1'b0;
                for (int k = 0; k < CIC_N; k++)
                    integ_q[k] <= '0;
            end else begin
                ds_valid_q <= dec;
                if (samp_en) begin
                    integ_q <= integ_d;
                    phase_q <= dec ? '0 : phase_q + RW'(1);
                end
                if (dec)
                    ds_q <= integ_d[CIC_N-1];
                if (comb_valid[CIC_N] && (warm_q != '0))
                    warm_q <= warm_q - WW'(1);
            end
        end
    end

    assign comb_data[0]  = ds_q;
    assign comb_valid[0] = ds_valid_q;

    for (genvar k = 0; k < CIC_N; k++) begin : g_comb
        cic_comb_stage #(
            .W (B_MAX),
            .M (CIC_M)
        ) u_comb (
            .clk       (clk),
            .reset     (reset),
            .flush     (cfg_acc),
            .in_valid  (comb_valid[k]),
            .in_data   (comb_data[k]),
            .out_valid (comb_valid[k+1]),
            .out_data  (comb_data[k+1])
        );
    end

    // Total shift is never negative for a legal shift, so modulo-width arithmetic is exact.
    assign sh_tot = {1'b0, shift_q} + (SHW+1)'(INP_DW - OUT_DW);

    always_comb begin
        scaled   = comb_data[CIC_N] >>> sh_tot;
        sat_data = scaled[OUT_DW-1:0];
        clip     = 1'b0;
        if (scaled > WMAX) begin
            sat_data = WMAX[OUT_DW-1:0];
            clip     = 1'b1;
        end else if (scaled < WMIN) begin
            sat_data = WMIN[OUT_DW-1:0];
            clip     = 1'b1;
        end
    end

    // Warm-up results are computed but neither strobed nor allowed to change the held output.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_samp_data <= '0;
            out_samp_str  <= 1'b0;
            out_sat       <= 1'b0;
        end else if (cfg_acc) begin
            out_samp_str <= 1'b0;
            out_sat      <= 1'b0;
        end else begin
            out_samp_str <= 1'b0;
            if (comb_valid[CIC_N] && (warm_q == '0)) begin
                out_samp_str  <= 1'b1;
                out_samp_data <= sat_data;
                if (clip)
                    out_sat <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_cic_d_prog.sv
// Self-checking bench for cic_d_prog: FIR-equivalent reference model feeding a scoreboard.
module tb_cic_d_prog;
    import cic_pkg::*;

    localparam int INP_DW    = 18;
    localparam int OUT_DW    = 18;
    localparam int R_MAX     = 64;
    localparam int N         = 5;
    localparam int M         = 1;
    localparam int SHIFT_RST = 30;
    localparam int B_MAX     = b_max_f(INP_DW, R_MAX, N, M);
    localparam int SHW       = shw_f(B_MAX);
    localparam int RW        = rw_f(R_MAX);

    typedef struct {
        longint data;
        bit     sat;
        int     cyc;
    } exp_t;

    logic                     clk = 1'b0;
    logic                     reset;
    logic signed [INP_DW-1:0] inp_samp_data;
    logic                     inp_samp_str;
    logic [RW-1:0]            cfg_ratio;
    logic [SHW-1:0]           cfg_shift;
    logic                     cfg_str;
    logic                     cfg_err;
    logic signed [OUT_DW-1:0] out_samp_data;
    logic                     out_samp_str;
    logic                     out_sat;

    int     n_checks = 0;
    int     n_pass   = 0;
    int     cyc      = 0;
    int     m_ratio, m_shift, m_phase, m_dec;
    bit     m_sat;
    longint last_out;
    longint hist[$];
    longint h[$];
    exp_t   sb[$];

    always #5 clk = ~clk;

    cic_d_prog #(
        .INP_DW    (INP_DW),
        .OUT_DW    (OUT_DW),
        .CIC_R_MAX (R_MAX),
        .CIC_N     (N),
        .CIC_M     (M),
        .SHIFT_RST (SHIFT_RST)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .inp_samp_data (inp_samp_data),
        .inp_samp_str  (inp_samp_str),
        .cfg_ratio     (cfg_ratio),
        .cfg_shift     (cfg_shift),
        .cfg_str       (cfg_str),
        .cfg_err       (cfg_err),
        .out_samp_data (out_samp_data),
        .out_samp_str  (out_samp_str),
        .out_sat       (out_sat)
    );

    task automatic check(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    endtask

    // Impulse response of ((1-z^-R)/(1-z^-1))^N: an N-fold convolution of length-R boxcars.
    task automatic compute_h(input int r);
        longint a[$];
        longint b[$];
        longint s;
        a = {1};
        for (int st = 0; st < N; st++) begin
            b = {};
            for (int i = 0; i < a.size() + r - 1; i++) begin
                s = 0;
                for (int j = 0; j < r; j++)
                    if (i - j >= 0 && i - j < a.size()) s += a[i-j];
                b.push_back(s);
            end
            a = b;
        end
        h = a;
    endtask

    task automatic flush_model(input int r, input int s);
        m_ratio = r;
        m_shift = s;
        m_phase = 0;
        m_dec   = 0;
        m_sat   = 1'b0;
        hist.delete();
        sb.delete();
        compute_h(r);
    endtask

    task automatic model_strobe(input longint x);
        longint y, v;
        int     n;
        bit     clipped;
        hist.push_back(x);
        if (m_phase == m_ratio - 1) begin
            m_phase = 0;
            m_dec++;
            if (m_dec > N) begin
                n = hist.size() - 1;
                y = 0;
                for (int k = 0; k < h.size() && k <= n; k++)
                    y += h[k] * hist[n-k];
                v = y >>> (m_shift + INP_DW - OUT_DW);
                clipped = 1'b0;
                if (v > 131071) begin v = 131071; clipped = 1'b1; end
                if (v < -131072) begin v = -131072; clipped = 1'b1; end
                m_sat = m_sat | clipped;
                sb.push_back('{data: v, sat: m_sat, cyc: cyc});
            end
        end else begin
            m_phase++;
        end
    endtask

    task automatic tick();
        exp_t e;
        @(posedge clk);
        cyc++;
        #1;
        if (out_samp_str) begin
            if (sb.size() == 0) begin
                check("unexp_str", out_samp_str, 0);
            end else begin
                e = sb.pop_front();
                check("data", out_samp_data, e.data);
                check("sat", out_sat, e.sat);
                check("latency", cyc - e.cyc, N + 2);
                last_out = e.data;
            end
        end
    endtask

    task automatic drive(input bit str, input longint x);
        reset         = 1'b0;
        cfg_str       = 1'b0;
        inp_samp_str  = str;
        inp_samp_data = INP_DW'(x);
        if (str) model_strobe(x);
        tick();
    endtask

    task automatic do_cfg(input int r, input int s, input bit str, input longint x);
        bit legal;
        legal         = (r >= 2) && (r <= R_MAX) && (s >= 0) && (s <= B_MAX - OUT_DW);
        reset         = 1'b0;
        cfg_ratio     = RW'(r);
        cfg_shift     = SHW'(s);
        cfg_str       = 1'b1;
        inp_samp_str  = str;
        inp_samp_data = INP_DW'(x);
        if (legal) flush_model(r, s);
        else if (str) model_strobe(x);
        tick();
        check("cfg_err", cfg_err, legal ? 0 : 1);
        cfg_str = 1'b0;
    endtask

    task automatic drain();
        int k;
        k = 0;
        while (sb.size() > 0 && k < 40) begin
            drive(1'b0, 0);
            k++;
        end
        check("drain", sb.size(), 0);
    endtask

    function automatic longint rnd_full();
        return longint'($urandom_range(0, 262143)) - 131072;
    endfunction

    initial begin
        reset         = 1'b1;
        inp_samp_str  = 1'b0;
        inp_samp_data = '0;
        cfg_str       = 1'b0;
        cfg_ratio     = '0;
        cfg_shift     = '0;
        last_out      = 0;
        flush_model(R_MAX, SHIFT_RST);
        repeat (3) tick();
        check("rst_data", out_samp_data, 0);
        check("rst_str", out_samp_str, 0);
        check("rst_err", cfg_err, 0);
        check("rst_sat", out_sat, 0);

        // Impulse through R=8, shift=15
        do_cfg(8, 15, 1'b0, 0);
        drive(1'b1, 1);
        repeat (8 * 10 - 1) drive(1'b1, 0);
        drain();

        // Saturation: full-scale negative input with one bit too little shift
        do_cfg(16, 19, 1'b0, 0);
        repeat (16 * 8) drive(1'b1, -131072);

        // Illegal configurations mid-stream leave the stream and sticky flag untouched
        do_cfg(1, 19, 1'b1, -131072);
        repeat (20) drive(1'b1, -131072);
        do_cfg(R_MAX + 1, 19, 1'b1, -131072);
        repeat (20) drive(1'b1, -131072);
        do_cfg(16, B_MAX, 1'b1, -131072);
        repeat (16 * 3) drive(1'b1, -131072);
        drain();
        check("sat_sticky", out_sat, 1);

        // DC gain: accepted cfg clears out_sat but keeps the held output
        do_cfg(16, 20, 1'b0, 0);
        check("sat_clr", out_sat, 0);
        check("held", out_samp_data, last_out);
        repeat (16 * 8) drive(1'b1, 100000);
        drain();
        check("dc_value", out_samp_data, 100000);

        // Reconfiguration coincident with a strobe in the middle of a random stream
        repeat (16 * 2 + 5) drive(1'b1, rnd_full());
        do_cfg(4, 10, 1'b1, rnd_full());
        repeat (4 * 10) drive(1'b1, rnd_full());
        drain();

        // Non-power-of-two ratio with gapped strobes, then reset mid-stream
        do_cfg(5, 12, 1'b0, 0);
        for (int i = 0; i < 150; i++)
            drive($urandom_range(0, 99) < 70, rnd_full());
        reset         = 1'b1;
        inp_samp_str  = 1'b1;
        cfg_str       = 1'b1;
        cfg_ratio     = RW'(4);
        cfg_shift     = SHW'(10);
        flush_model(R_MAX, SHIFT_RST);
        last_out = 0;
        tick();
        check("rst2_data", out_samp_data, 0);
        check("rst2_str", out_samp_str, 0);
        check("rst2_err", cfg_err, 0);
        check("rst2_sat", out_sat, 0);
        for (int i = 0; i < 2400; i++)
            drive($urandom_range(0, 99) < 30, longint'($urandom_range(0, 40000)) + 30000);
        drain();
        repeat (20) drive(1'b0, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
